// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller for the MIPS core: sequences fetch/decode/execute/memory/writeback.
// Optional build macro MCTRL_ILLEGAL_TRAP_EN: unrecognised opcodes trap instead of acting as NOPs.
//
// state    | meaning
// IDLE     | post-reset, no request outstanding
// FETCH    | read instruction at PC, PC += 4
// DECODE   | dispatch on opcode, branch target into ALUOut
// EXEC_R   | R-type ALU operation
// EXEC_I   | immediate ALU operation
// MEM_ADDR | load/store address calculation
// MEM_RD   | load data read
// MEM_WR   | store data write
// WB_ALU   | write ALU result to register file
// WB_MEM   | write loaded data to register file
// BRANCH   | BEQ compare and conditional PC write
// JUMP     | PC <- jump target
// TRAP     | illegal opcode, held until reset
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWe,
  output logic        iOrD,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        pcWriteCond,
  output logic [1:0]  ctrlPCSrc,
  output logic [1:0]  ctrlRegDst,
  output logic [1:0]  ctrlMemToReg,
  output logic [2:0]  ctrlALUOp,
  output logic        ctrlALUSrcA,
  output logic [1:0]  ctrlALUSrcB,
  output logic        ctrlRegWrite,
  output logic        ctrlImmExtend,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instrCount
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_ADDU  = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;

  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                                   state_d = S_EXEC_R;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                               state_d = S_MEM_ADDR;
          OP_BEQ:                                     state_d = S_BRANCH;
          OP_J:                                       state_d = S_JUMP;
`ifdef MCTRL_ILLEGAL_TRAP_EN
          default:                                    state_d = S_TRAP;
`else
          default:                                    state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R:   state_d = S_WB_ALU;
      S_EXEC_I:   state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (memReady) state_d = S_WB_MEM;
      S_MEM_WR:   if (memReady) state_d = S_FETCH;
      S_WB_ALU:   state_d = S_FETCH;
      S_WB_MEM:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  // Every completed instruction re-enters FETCH from somewhere other than IDLE/FETCH.
  assign retire  = (state_d == S_FETCH) && (state_q != S_IDLE) && (state_q != S_FETCH);
  assign count_d = retire ? count_q + 32'd1 : count_q;

  always_comb begin
    memReq        = 1'b0;
    memWe         = 1'b0;
    iOrD          = 1'b0;
    irWrite       = 1'b0;
    pcWrite       = 1'b0;
    pcWriteCond   = 1'b0;
    ctrlPCSrc     = 2'b00;
    ctrlRegDst    = 2'b00;
    ctrlMemToReg  = 2'b00;
    ctrlALUOp     = ALU_FUNCT;
    ctrlALUSrcA   = 1'b0;
    ctrlALUSrcB   = 2'b00;
    ctrlRegWrite  = 1'b0;
    ctrlImmExtend = 1'b0;
    case (state_q)
      S_FETCH: begin
        memReq      = 1'b1;
        irWrite     = memReady;
        pcWrite     = memReady;
        ctrlALUSrcB = 2'b01;
        ctrlALUOp   = ALU_ADDU;
      end
      S_DECODE: begin
        ctrlALUSrcB   = 2'b11;
        ctrlALUOp     = ALU_ADD;
        ctrlImmExtend = 1'b1;
      end
      S_EXEC_R: begin
        ctrlALUSrcA = 1'b1;
        ctrlALUOp   = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ctrlALUSrcA = 1'b1;
        ctrlALUSrcB = 2'b10;
        case (opcode)
          OP_ADDI:  begin ctrlALUOp = ALU_ADD;  ctrlImmExtend = 1'b1; end
          OP_ADDIU: begin ctrlALUOp = ALU_ADDU; ctrlImmExtend = 1'b1; end
          OP_ANDI:  ctrlALUOp = ALU_AND;
          OP_ORI:   ctrlALUOp = ALU_OR;
          OP_XORI:  ctrlALUOp = ALU_XOR;
          default:  ctrlALUOp = ALU_FUNCT;
        endcase
      end
      S_MEM_ADDR: begin
        ctrlALUSrcA   = 1'b1;
        ctrlALUSrcB   = 2'b10;
        ctrlALUOp     = ALU_ADD;
        ctrlImmExtend = 1'b1;
      end
      S_MEM_RD: begin
        memReq = 1'b1;
        iOrD   = 1'b1;
      end
      S_MEM_WR: begin
        memReq = 1'b1;
        memWe  = 1'b1;
        iOrD   = 1'b1;
      end
      S_WB_ALU: begin
        ctrlRegWrite = 1'b1;
        ctrlRegDst   = (opcode == OP_RTYPE) ? 2'b01 : 2'b00;
      end
      S_WB_MEM: begin
        ctrlRegWrite = 1'b1;
        ctrlMemToReg = 2'b01;
      end
      S_BRANCH: begin
        ctrlALUSrcA = 1'b1;
        ctrlALUOp   = ALU_SUB;
        pcWriteCond = 1'b1;
        ctrlPCSrc   = 2'b01;
      end
      S_JUMP: begin
        pcWrite   = 1'b1;
        ctrlPCSrc = 2'b10;
      end
      default: ;
    endcase
  end

`ifdef MCTRL_ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

  assign state      = state_q;
  assign instrCount = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level path model checked every cycle, plus directed literals.
// Honours MCTRL_ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        memReady = 1'b1;
  logic        memReq, memWe, iOrD, irWrite, pcWrite, pcWriteCond;
  logic [1:0]  ctrlPCSrc, ctrlRegDst, ctrlMemToReg, ctrlALUSrcB;
  logic [2:0]  ctrlALUOp;
  logic        ctrlALUSrcA, ctrlRegWrite, ctrlImmExtend, illegal;
  logic [3:0]  state;
  logic [31:0] instrCount;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
    .memReq(memReq), .memWe(memWe), .iOrD(iOrD), .irWrite(irWrite),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .ctrlPCSrc(ctrlPCSrc),
    .ctrlRegDst(ctrlRegDst), .ctrlMemToReg(ctrlMemToReg), .ctrlALUOp(ctrlALUOp),
    .ctrlALUSrcA(ctrlALUSrcA), .ctrlALUSrcB(ctrlALUSrcB), .ctrlRegWrite(ctrlRegWrite),
    .ctrlImmExtend(ctrlImmExtend), .state(state), .illegal(illegal),
    .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] R_T = 6'b000000, J_T = 6'b000010, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ADDIU = 6'b001001, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, XORI = 6'b001110, LW = 6'b100011, SW = 6'b101011;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- model: each instruction is a list of steps after DECODE ----------------
  int          m_st = 0;
  int          m_path[$];
  logic [31:0] m_cnt = '0;
  bit          m_valid = 1'b0;

  function automatic void plan(input logic [5:0] op);
    m_path.delete();
    case (op)
      R_T:                           m_path = '{3, 8, 1};
      ADDI, ADDIU, ANDI, ORI, XORI:  m_path = '{4, 8, 1};
      LW:                            m_path = '{5, 6, 9, 1};
      SW:                            m_path = '{5, 7, 1};
      BEQ:                           m_path = '{10, 1};
      J_T:                           m_path = '{11, 1};
`ifdef MCTRL_ILLEGAL_TRAP_EN
      default:                       m_path = '{12};
`else
      default:                       m_path = '{1};
`endif
    endcase
  endfunction

  function automatic void model_step(input logic r, input logic rdy, input logic [5:0] op);
    int prev;
    prev = m_st;
    if (r) begin
      m_st = 0; m_cnt = '0; m_path.delete(); m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      if (rdy) m_st = 2;
    end else if (m_st == 6 || m_st == 7) begin
      if (rdy) m_st = m_path.pop_front();
    end else if (m_st == 2) begin
      plan(op);
      m_st = m_path.pop_front();
    end else if (m_st != 12) m_st = m_path.pop_front();
    if (m_st == 1 && prev != 0 && prev != 1) m_cnt = m_cnt + 32'd1;
  endfunction

  // {memReq,memWe,iOrD,irWrite,pcWrite,pcWriteCond,PCSrc,RegDst,MemToReg,ALUOp,SrcA,SrcB,RegWrite,ImmExt,state,illegal}
  function automatic logic [24:0] exp_out(input int st, input logic [5:0] op, input logic rdy);
    logic rq, we, iod, irw, pcw, pcwc, srca, rw, imm, ill;
    logic [1:0] pcsrc, rdst, m2r, srcb;
    logic [2:0] aluop;
    {rq, we, iod, irw, pcw, pcwc, srca, rw, imm, ill} = '0;
    {pcsrc, rdst, m2r, srcb} = '0;
    aluop = 3'b000;
    case (st)
      1:  begin rq = 1; srcb = 2'b01; aluop = 3'b010; irw = rdy; pcw = rdy; end
      2:  begin srcb = 2'b11; aluop = 3'b001; imm = 1; end
      3:  begin srca = 1; end
      4: begin
        srca = 1; srcb = 2'b10;
        if (op == ADDI)       begin aluop = 3'b001; imm = 1; end
        else if (op == ADDIU) begin aluop = 3'b010; imm = 1; end
        else if (op == ANDI)  aluop = 3'b011;
        else if (op == ORI)   aluop = 3'b100;
        else if (op == XORI)  aluop = 3'b101;
      end
      5:  begin srca = 1; srcb = 2'b10; aluop = 3'b001; imm = 1; end
      6:  begin rq = 1; iod = 1; end
      7:  begin rq = 1; we = 1; iod = 1; end
      8:  begin rw = 1; rdst = (op == R_T) ? 2'b01 : 2'b00; end
      9:  begin rw = 1; m2r = 2'b01; end
      10: begin srca = 1; aluop = 3'b110; pcwc = 1; pcsrc = 2'b01; end
      11: begin pcw = 1; pcsrc = 2'b10; end
      12: ill = 1;
      default: ;
    endcase
    return {rq, we, iod, irw, pcw, pcwc, pcsrc, rdst, m2r, aluop, srca, srcb, rw, imm, 4'(st), ill};
  endfunction

  wire [24:0] dut_vec = {memReq, memWe, iOrD, irWrite, pcWrite, pcWriteCond, ctrlPCSrc,
                         ctrlRegDst, ctrlMemToReg, ctrlALUOp, ctrlALUSrcA, ctrlALUSrcB,
                         ctrlRegWrite, ctrlImmExtend, state, illegal};

  initial begin
    logic s_rst, s_rdy;
    logic [5:0] s_op;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("ctrl", 64'(dut_vec), 64'(exp_out(m_st, opcode, memReady)));
        check("instrCount", 64'(instrCount), 64'(m_cnt));
      end
      s_rst = rst; s_rdy = memReady; s_op = opcode;
      @(posedge clk);
      model_step(s_rst, s_rdy, s_op);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; memReady = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", 64'(state), 64'd0);
    check("rst_memReq", 64'(memReq), 64'd0);
    check("rst_count", 64'(instrCount), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    tick();
    check("first_memReq", 64'(memReq), 64'd1);
    check("first_fetch", 64'(state), 64'd1);
  endtask

  // Starts in the first FETCH cycle, ends in the first FETCH cycle of the next instruction.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           output int cycles, output int irw_pulses);
    int wc;
    logic [3:0] prev;
    wc = 0; cycles = 0; irw_pulses = 0;
    opcode = op;
    do begin
      prev = state;
      if (state == 4'd1)                       memReady = (wc >= fw);
      else if (state == 4'd6 || state == 4'd7) memReady = (wc >= mw);
      else                                     memReady = 1'b1;
      #1;
      if (irWrite) irw_pulses++;
      tick();
      cycles++;
      if (state != prev) wc = 0; else wc++;
    end while (!(state == 4'd1 && prev != 4'd1) && cycles < 60);
    check("no_timeout", 64'(cycles < 60), 64'd1);
  endtask

  initial begin
    int c, p;
    do_reset();

    // ADDI walked by hand
    opcode = ADDI; memReady = 1'b1; #1;
    check("addi_irWrite", 64'(irWrite), 64'd1);
    check("addi_pcWrite", 64'(pcWrite), 64'd1);
    tick(); check("addi_decode", 64'(state), 64'd2);
    tick(); check("addi_exec", 64'(state), 64'd4);
    check("addi_aluop", 64'(ctrlALUOp), 64'd1);
    check("addi_srcb", 64'(ctrlALUSrcB), 64'd2);
    check("addi_imm", 64'(ctrlImmExtend), 64'd1);
    tick(); check("addi_wb", 64'(state), 64'd8);
    check("addi_regwrite", 64'(ctrlRegWrite), 64'd1);
    check("addi_regdst", 64'(ctrlRegDst), 64'd0);
    tick(); check("addi_refetch", 64'(state), 64'd1);
    check("addi_count", 64'(instrCount), 64'd1);

    run_instr(R_T, 0, 0, c, p);   check("rtype_cycles", 64'(c), 64'd4);
    run_instr(LW, 3, 3, c, p);    check("lw_cycles", 64'(c), 64'd11);
    check("lw_irwrite_pulses", 64'(p), 64'd1);
    run_instr(SW, 0, 0, c, p);    check("sw_cycles", 64'(c), 64'd4);
    run_instr(BEQ, 0, 0, c, p);   check("beq_cycles", 64'(c), 64'd3);
    run_instr(J_T, 0, 0, c, p);   check("j_cycles", 64'(c), 64'd3);
    run_instr(ANDI, 0, 0, c, p);  check("andi_cycles", 64'(c), 64'd4);
    run_instr(ORI, 1, 0, c, p);   check("ori_cycles", 64'(c), 64'd5);
    run_instr(XORI, 0, 0, c, p);  check("xori_cycles", 64'(c), 64'd4);
    run_instr(ADDIU, 0, 0, c, p); check("addiu_cycles", 64'(c), 64'd4);
    run_instr(SW, 0, 2, c, p);    check("sw_wait_cycles", 64'(c), 64'd6);
    check("count_after_mix", 64'(instrCount), 64'd11);

`ifdef MCTRL_ILLEGAL_TRAP_EN
    opcode = 6'b111111; memReady = 1'b1;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      check("trap_state", 64'(state), 64'd12);
      check("trap_illegal", 64'(illegal), 64'd1);
      tick();
    end
    check("trap_count", 64'(instrCount), 64'd11);
    do_reset();
`else
    run_instr(6'b111111, 0, 0, c, p);
    check("nop_cycles", 64'(c), 64'd2);
    check("nop_count", 64'(instrCount), 64'd12);
    do_reset();
`endif

    // reset while a store waits on memReady
    run_instr(ADDI, 0, 0, c, p);
    check("pre_abort_count", 64'(instrCount), 64'd1);
    opcode = SW; memReady = 1'b1;
    tick(); tick();
    memReady = 1'b0;
    tick();
    check("abort_in_memwr", 64'(state), 64'd7);
    check("abort_memreq", 64'(memReq), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    check("abort_state", 64'(state), 64'd0);
    check("abort_memreq_low", 64'(memReq), 64'd0);
    check("abort_count", 64'(instrCount), 64'd0);
    rst = 1'b0; memReady = 1'b1;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
